// File: rtl/parity_fifo.sv
// Single-clock show-ahead FIFO whose head word is parity-checked before it is offered downstream.
// Build with PARITY_CHECK_EN defined to drop corrupt head words; otherwise every stored word is delivered.

module parity_fifo_ram #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] memory [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      memory[waddr] <= wdata;
    end
  end

  // Combinational read so the head word is visible the cycle after it lands.
  assign rdata = memory[raddr];

endmodule

module parity_fifo_core #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             push_valid_i,
  output logic             push_grant_o,
  input  logic             pop_grant_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             not_empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0] count_write;
  logic [AW-1:0] count_read;
  logic [CW-1:0] count_fifo;
  logic          wr_en;
  logic          rd_en;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
    return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign push_grant_o = (count_fifo != CW'(DEPTH));
  assign not_empty_o  = (count_fifo != '0);
  assign wr_en        = push_valid_i && push_grant_o;
  assign rd_en        = pop_grant_i && not_empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_write <= '0;
      count_read  <= '0;
      count_fifo  <= '0;
    end else begin
      if (wr_en) begin
        count_write <= next_ptr(count_write);
      end
      if (rd_en) begin
        count_read <= next_ptr(count_read);
      end
      if (wr_en && !rd_en) begin
        count_fifo <= count_fifo + 1'b1;
      end else if (!wr_en && rd_en) begin
        count_fifo <= count_fifo - 1'b1;
      end
    end
  end

  parity_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) my_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (count_write),
    .wdata (push_data_i),
    .raddr (count_read),
    .rdata (pop_data_o)
  );

endmodule

module parity_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int EVEN_ODD   = 0,
  parameter int PARITY_BIT = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_WIDTH:0] push_data_i,
  input  logic                push_valid_i,
  output logic                push_grant_o,
  input  logic                pop_grant_i,
  output logic [DATA_WIDTH:0] pop_data_o,
  output logic                pop_valid_o
);

  logic not_empty;
  logic head_ok;
  logic core_pop;

  // Reject configurations the parity logic cannot represent.
  if (FIFO_DEPTH < 1 || (EVEN_ODD != 0 && EVEN_ODD != 1) ||
      (PARITY_BIT != 0 && PARITY_BIT != 1)) begin : g_bad_cfg
    $error("parity_fifo: unsupported parameter combination");
  end

`ifdef PARITY_CHECK_EN
  // Parity covers the whole stored word, so the parity bit position does not change the check.
  localparam logic PARITY_TARGET = (EVEN_ODD != 0);
  assign head_ok = ((^pop_data_o) == PARITY_TARGET);
`else
  assign head_ok = 1'b1;
`endif

  assign pop_valid_o = not_empty && head_ok;
  // A corrupt head is discarded on its own, without waiting for the consumer.
  assign core_pop    = (pop_valid_o && pop_grant_i) || (not_empty && !head_ok);

  parity_fifo_core #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) fifo_i (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_data_i  (push_data_i),
    .push_valid_i (push_valid_i),
    .push_grant_o (push_grant_o),
    .pop_grant_i  (core_pop),
    .pop_data_o   (pop_data_o),
    .not_empty_o  (not_empty)
  );

endmodule

// File: tb/tb_parity_fifo.sv
// Randomised and directed bench for parity_fifo against a queue-based reference model.
// Expectations follow PARITY_CHECK_EN the same way the design does.

module tb_parity_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int W     = DW + 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] push_data = '0;
  logic         push_valid = 1'b0;
  logic         pop_grant = 1'b0;
  logic         push_grant;
  logic [W-1:0] pop_data;
  logic         pop_valid;

  int vectors = 0;
  int errors  = 0;

  logic [W-1:0] q[$];    // model contents, head first
  logic [W-1:0] rx[$];   // words the consumer actually took from the DUT
  logic [W-1:0] acc[$];  // words the model says were accepted
  int phase = 0;
  int max_cnt [8] = '{default: 0};
  int drops   [8] = '{default: 0};
  int toggles [8] = '{default: 0};
  logic prev_grant = 1'b1;

  parity_fifo #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .EVEN_ODD   (0),
    .PARITY_BIT (0)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_data_i  (push_data),
    .push_valid_i (push_valid),
    .push_grant_o (push_grant),
    .pop_grant_i  (pop_grant),
    .pop_data_o   (pop_data),
    .pop_valid_o  (pop_valid)
  );

  always #5 clk = ~clk;

  function automatic bit good(input logic [W-1:0] w);
`ifdef PARITY_CHECK_EN
    return (^w) == 1'b0;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [W-1:0] mk(input int unsigned payload);
    logic [W-1:0] w;
    w = {payload[DW-1:0], 1'b0};
    w[0] = ^w;
    return w;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue; a bad head leaves on its own, a good one on pop_grant.
  always @(posedge clk or negedge rst_n) begin : model
    int  n;
    bit  do_pop;
    if (!rst_n) begin
      q.delete();
    end else begin
      n = q.size();
      do_pop = (n != 0) && (!good(q[0]) || pop_grant);
      if (do_pop) void'(q.pop_front());
      if (push_valid && n != DEPTH) begin
        q.push_back(push_data);
        acc.push_back(push_data);
      end
    end
  end

  always @(negedge clk) begin : compare
    bit head_good;
    if (rst_n) begin
      head_good = (q.size() != 0) && good(q[0]);
      check("push_grant", 64'(push_grant), 64'(q.size() != DEPTH));
      check("pop_valid", 64'(pop_valid), 64'(head_good));
      check("count_fifo", 64'(dut.fifo_i.count_fifo), 64'(q.size()));
      check("core_pop", 64'(dut.fifo_i.pop_grant_i),
            64'((q.size() != 0) && (!head_good || pop_grant)));
      if (q.size() != 0) check("pop_data", 64'(pop_data), 64'(q[0]));
      if (pop_valid && pop_grant) rx.push_back(pop_data);
      if (int'(dut.fifo_i.count_fifo) > max_cnt[phase]) max_cnt[phase] <= int'(dut.fifo_i.count_fifo);
      if (dut.fifo_i.pop_grant_i && !pop_valid) drops[phase] <= drops[phase] + 1;
      if (push_grant != prev_grant) toggles[phase] <= toggles[phase] + 1;
      prev_grant <= push_grant;
    end
  end

  task automatic drive(input bit pv, input logic [W-1:0] d, input bit pg);
    push_valid = pv;
    push_data  = d;
    pop_grant  = pg;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rx(input string name, input int start, input logic [W-1:0] exp[$]);
    check({name, "_count"}, 64'(rx.size() - start), 64'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (start + i < rx.size()) check({name, "_word"}, 64'(rx[start + i]), 64'(exp[i]));
    end
  endtask

  initial begin
    int rs;
    int as;
    logic [W-1:0] expq[$];

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Mid-cycle reset with words stored
    phase = 0;
    drive(1'b1, 33'h3, 1'b0);
    drive(1'b1, 33'h5, 1'b0);
    drive(1'b0, '0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("rst_push_grant", 64'(push_grant), 64'd1);
    check("rst_pop_valid", 64'(pop_valid), 64'd0);
    check("rst_count_fifo", 64'(dut.fifo_i.count_fifo), 64'd0);
    check("rst_count_write", 64'(dut.fifo_i.count_write), 64'd0);
    check("rst_count_read", 64'(dut.fifo_i.count_read), 64'd0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Overflow then drain/underflow
    phase = 1;
    rs = rx.size();
    expq = '{33'h3, 33'h5, 33'h6, 33'h9, 33'hA, 33'hC};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, expq[i], 1'b0);
      if (i == 3) check("full_grant", 64'(push_grant), 64'd0);
    end
    check("full_count", 64'(dut.fifo_i.count_fifo), 64'd4);
    for (int i = 0; i < 6; i++) drive(1'b0, '0, 1'b1);
    check("drain_valid", 64'(pop_valid), 64'd0);
    check("drain_count", 64'(dut.fifo_i.count_fifo), 64'd0);
    expect_rx("drain", rs, '{33'h3, 33'h5, 33'h6, 33'h9});

    // Corrupt word in the middle
    phase = 2;
    rs = rx.size();
    drive(1'b1, 33'h3, 1'b0);
    drive(1'b1, 33'h7, 1'b0);
    drive(1'b1, 33'h5, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b1);
`ifdef PARITY_CHECK_EN
    expect_rx("parity", rs, '{33'h3, 33'h5});
    check("parity_drops", 64'(drops[2]), 64'd1);
`else
    expect_rx("parity", rs, '{33'h3, 33'h7, 33'h5});
    check("parity_drops", 64'(drops[2]), 64'd0);
`endif

    // Concurrent push and pop
    phase = 3;
    rs = rx.size();
    expq.delete();
    for (int k = 0; k < 30; k++) begin
      drive(1'b1, mk(3 * k), 1'b1);
      expq.push_back(mk(3 * k));
    end
    for (int i = 0; i < 2; i++) drive(1'b0, '0, 1'b1);
    expect_rx("concurrent", rs, expq);
    check("concurrent_max_le1", 64'(max_cnt[3] <= 1), 64'd1);

    // Burst: push every cycle, pop every other cycle
    phase = 4;
    rs = rx.size();
    as = acc.size();
    for (int c = 0; c < 30; c++) drive(1'b1, mk(100 + c), c[0]);
    for (int i = 0; i < 6; i++) drive(1'b0, '0, 1'b1);
    expq.delete();
    for (int i = as; i < acc.size(); i++) expq.push_back(acc[i]);
    expect_rx("burst", rs, expq);
    check("burst_max", 64'(max_cnt[4]), 64'd4);
    check("burst_toggles", 64'(toggles[4] > 2), 64'd1);

    // Random traffic including corrupt words
    phase = 5;
    for (int c = 0; c < 400; c++) begin
      logic [W-1:0] d;
      d = {$urandom(), 1'($urandom_range(0, 1))};
      if ($urandom_range(0, 3) != 0) d = mk(d[W-1:1]);
      drive(1'($urandom_range(0, 3) != 0), d, 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 6; i++) drive(1'b0, '0, 1'b1);
    check("final_empty", 64'(pop_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
